// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin adder-sharing arbiter.
// Optional feature macro used by the arbiter: ADD_CHAIN_EN (chained multi-word adds).
package adder_arb_pkg;

    localparam int ADD_W    = 5;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // First set bit of valid at or after ptr, scanning modulo n (n <= MAX_REQ).
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int                  n
    );
        logic [MAX_ID_W-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && (i < n) && valid[idx[MAX_ID_W-1:0]]) begin
                pick  = idx[MAX_ID_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// Requester/consumer bus of the adder-sharing arbiter; slave = arbiter side.
// req_chain exists only when ADD_CHAIN_EN is defined.
interface adder_share_arb_if
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*ADD_W-1:0] req_a;
    logic [N_REQ*ADD_W-1:0] req_b;
    logic [N_REQ-1:0]       req_ci;
`ifdef ADD_CHAIN_EN
    logic [N_REQ-1:0]       req_chain;
`endif
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ADD_W-1:0]       rsp_sum;
    logic                   rsp_co;
    logic [ID_W-1:0]        rsp_id;

    modport slave (
        input  req_valid, req_a, req_b, req_ci,
`ifdef ADD_CHAIN_EN
        input  req_chain,
`endif
        output req_ready,
        output rsp_valid, rsp_sum, rsp_co, rsp_id,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_ci,
`ifdef ADD_CHAIN_EN
        output req_chain,
`endif
        input  req_ready,
        input  rsp_valid, rsp_sum, rsp_co, rsp_id,
        output rsp_ready
    );

endinterface

// File: rtl/my_sum.sv
// 5-bit ripple-carry adder shared by all requesters of the arbiter.
module my_sum
    import adder_arb_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             ci,
    output logic [ADD_W-1:0] sum,
    output logic             co
);

    // Carry kept in a procedural variable so the ripple is one combinational chain.
    always_comb begin
        logic carry;
        carry = ci;
        sum   = '0;
        for (int i = 0; i < ADD_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one my_sum adder among N_REQ requesters, one result held.
// Define ADD_CHAIN_EN to enable chained multi-word adds (lock on requester, carry forwarding).
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_share_arb_if.slave  bus
);

    arb_state_t       state_reg;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic [ADD_W-1:0] rsp_sum_reg;
    logic             rsp_co_reg;

    logic [N_REQ-1:0]   elig_valid;
    logic [MAX_REQ-1:0] valid_ext;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    ptr_next;
    logic               can_accept;
    logic               accept;
    logic [ADD_W-1:0]   a_mux;
    logic [ADD_W-1:0]   b_mux;
    logic               ci_mux;
    logic [ADD_W-1:0]   sum_w;
    logic               co_w;

`ifdef ADD_CHAIN_EN
    logic             lock_reg;
    logic [ID_W-1:0]  lock_id_reg;
    logic             chain_c_reg;
`endif

    always_comb begin
        elig_valid = bus.req_valid;
`ifdef ADD_CHAIN_EN
        // While locked only the chain owner may be granted; others stall.
        if (lock_reg) begin
            elig_valid = bus.req_valid & (N_REQ'(1) << lock_id_reg);
        end
`endif
        valid_ext             = '0;
        valid_ext[N_REQ-1:0]  = elig_valid;
        grant                 = ID_W'(rr_pick(valid_ext, MAX_ID_W'(rr_ptr_reg), N_REQ));
        can_accept            = (state_reg == IDLE) | bus.rsp_ready;
        accept                = can_accept & (|elig_valid);
        bus.req_ready         = accept ? (N_REQ'(1) << grant) : '0;
        ptr_next              = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;

        a_mux  = bus.req_a[int'(grant)*ADD_W +: ADD_W];
        b_mux  = bus.req_b[int'(grant)*ADD_W +: ADD_W];
        ci_mux = bus.req_ci[grant];
`ifdef ADD_CHAIN_EN
        if (lock_reg) begin
            ci_mux = chain_c_reg;
        end
`endif
    end

    my_sum u_sum (
        .a   (a_mux),
        .b   (b_mux),
        .ci  (ci_mux),
        .sum (sum_w),
        .co  (co_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            rsp_id_reg  <= '0;
            rsp_sum_reg <= '0;
            rsp_co_reg  <= 1'b0;
`ifdef ADD_CHAIN_EN
            lock_reg    <= 1'b0;
            lock_id_reg <= '0;
            chain_c_reg <= 1'b0;
`endif
        end else begin
            if (accept) begin
                state_reg   <= HOLD;
                rsp_sum_reg <= sum_w;
                rsp_co_reg  <= co_w;
                rsp_id_reg  <= grant;
                rr_ptr_reg  <= ptr_next;
`ifdef ADD_CHAIN_EN
                chain_c_reg <= co_w;
                lock_reg    <= bus.req_chain[grant];
                lock_id_reg <= grant;
`endif
            end else if ((state_reg == HOLD) && bus.rsp_ready) begin
                state_reg <= IDLE;
            end
        end
    end

    assign bus.rsp_valid = (state_reg == HOLD);
    assign bus.rsp_sum   = rsp_sum_reg;
    assign bus.rsp_co    = rsp_co_reg;
    assign bus.rsp_id    = rsp_id_reg;

endmodule
